// File: rtl/banked_dmem_arbiter.sv
// banked_dmem_arbiter: four-port data memory split into four word-interleaved
// banks. Each bank grants one requesting core per cycle using its own
// round-robin pointer; losers are stalled combinationally and must hold their
// request. Writes commit at the grant edge, read data follows one cycle later.
// Optional feature macro: DMEM_ARB_STATS_EN adds per-bank conflict counters.
module banked_dmem_arbiter #(
  parameter int WORDS_PER_BANK = 256,
  parameter     INIT_FILE      = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_read,
  input  logic [3:0]   req_write,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_wdata,
  output logic [3:0]   stall,
  output logic [3:0]   rsp_valid,
  output logic [127:0] rsp_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [127:0] conflict_count
`endif
);

  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(WORDS_PER_BANK);
  localparam int WADDR_W = IDX_W + 2;
  localparam int DEPTH   = 4 * WORDS_PER_BANK;

  // Word-linear storage: word address = {index, bank}.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [3:0]               active;
  logic [3:0]               is_read;
  logic [3:0]               grant;
  logic [3:0]               unused_addr;
  logic [3:0][1:0]          core_bank;
  logic [3:0][WADDR_W-1:0]  core_waddr;
  logic [3:0][3:0]          bank_req;
  logic [3:0][1:0]          ptr;
  logic [3:0][1:0]          ptr_nxt;
  logic [3:0]               wr_en;
  logic [3:0][WADDR_W-1:0]  wr_addr;
  logic [3:0][DATA_W-1:0]   wr_data;

  // Per-core decode; byte offset and bits above the memory size are ignored.
  for (genvar i = 0; i < 4; i++) begin : g_core
    assign core_bank[i]   = req_addr[32*i+2 +: 2];
    assign core_waddr[i]  = req_addr[32*i+2 +: WADDR_W];
    assign unused_addr[i] = ^{req_addr[32*i +: 2],
                              req_addr[32*i+WADDR_W+2 +: 32-WADDR_W-2]};
  end

  // A write takes priority when both read and write are set on one core.
  assign active  = req_read | req_write;
  assign is_read = req_read & ~req_write;
  assign stall   = active & ~grant;

  // Requester mask per bank: bank_req[b][i] is core i asking for bank b.
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        bank_req[b][i] = active[i] && (core_bank[i] == 2'(b));
      end
    end
  end

  // Round-robin search from each bank's pointer; winner's write is steered
  // to that bank's write port and the pointer moves just past the winner.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    grant   = '0;
    ptr_nxt = ptr;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    found   = 1'b0;
    cand    = '0;
    for (int b = 0; b < 4; b++) begin
      found = 1'b0;
      for (int off = 0; off < 4; off++) begin
        cand = ptr[b] + 2'(off);
        if (!found && bank_req[b][cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          ptr_nxt[b]  = cand + 2'd1;
          if (req_write[cand]) begin
            wr_en[b]   = 1'b1;
            wr_addr[b] = core_waddr[cand];
            wr_data[b] = req_wdata[DATA_W*cand +: DATA_W];
          end
        end
      end
    end
  end

  // Bank storage write ports, one per bank; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en[b]) begin
        mem[wr_addr[b]] <= wr_data[b];
      end
    end
  end

  // Arbitration pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  // Read response register: valid for one cycle, data held until next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= grant & is_read;
      for (int i = 0; i < 4; i++) begin
        if (grant[i] && is_read[i]) begin
          rsp_rdata[DATA_W*i +: DATA_W] <= mem[core_waddr[i]];
        end
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count cycles in which a bank saw two or more requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_count <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if ($countones(bank_req[b]) >= 2) begin
          conflict_count[32*b +: 32] <= sat_inc(conflict_count[32*b +: 32]);
        end
      end
    end
  end
`endif

endmodule
